seg_display_mux: RTL and testbench
==================================

# seg_display_mux

Four-digit time-multiplexed seven-segment driver for the Basys 3 clock, sitting directly downstream of the hours and minutes counters. It takes binary hours (1–12) and minutes (0–59), splits them into decimal digits and drives the board's shared-cathode segment bus and per-digit anodes. It also scans the digits at a fixed refresh rate, blanks a leading hours zero and blinks the centre decimal point as a colon.

## Interface
- REFRESH_DIV, default 100000: clk cycles per digit slot (1 ms at 100 MHz, 4 ms frame).
- GHOST_CYC, default 4: cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.
- BLINK_DIV, default 50000000: clk cycles per colon half-period (0.5 s at 100 MHz).
- clk_100MHz input 1: system clock, all logic on rising edge.
- reset input 1: synchronous, active-high.
- hours input 4: binary hours, legal 1–12.
- minutes input 6: binary minutes, legal 0–59.
- seg output 7: segments a..g on seg[0]..seg[6], active-low.
- dp output 1: decimal point, active-low.
- an output 4: digit anodes, active-low; an[3] is the leftmost digit (hours tens), an[0] is the rightmost (minutes ones).

## Operation
- Refresh counter counts 0..REFRESH_DIV-1 and wraps. The 2-bit digit index increments on wrap: 0→1→2→3→0. Index 0 drives an[0].
- Frame latch: hours and minutes are sampled into shadow registers only when the refresh counter wraps while the index is 3, so one frame always shows a coherent value. After reset the shadows hold 12:00.
- Digit values, computed from the shadows:
  - d3 = hours tens
  - d2 = hours ones
  - d1 = minutes tens
  - d0 = minutes ones
- Leading blank: d3 is blank (seg = 7'h7F) when the shadow hours < 10.
- Invalid input: if shadow hours is 0 or >12, or shadow minutes >59, all four digits show a dash (only segment g lit, seg = 7'h3F). dp stays off in this case.
- Colon: a blink counter runs 0..BLINK_DIV-1 and toggles colon_on on wrap; it resets to colon_on = 1. dp is driven low only while index = 2 and colon_on = 1 and input is valid.
- Ghost blanking: while the refresh counter < GHOST_CYC, an = 4'hF. seg and dp may change during this window.
- Font: standard 0–9 patterns. 7 lights a, b, c; 1 lights b, c.

## Timing
- All outputs are registered. Reset values:
  - seg = 7'h7F, dp = 1, an = 4'hF
  - refresh counter = 0, index = 0, blink counter = 0, colon_on = 1, shadows = 12:00
- The first anode asserts (an = 4'b1110) on the output edge GHOST_CYC+1 cycles after the cycle in which reset is sampled low.
- seg/dp/an reflect the current index and counter with exactly 1 cycle of latency.
- Input-change latency: a change becomes visible after at most 4×REFRESH_DIV+1 cycles, at the next frame boundary.
- Reset asserted mid-slot: all counters and outputs take their reset values on the next edge, and no anode stays asserted.
- Simultaneous refresh wrap and blink wrap: both take effect on the same edge, with no priority interaction.
- Inputs are synchronous to clk_100MHz. No input synchronizers are required.

## Structure
- Shared package seg_pkg holds:
  - NUM_DIGITS = 4
  - SEG_BLANK = 7'h7F, SEG_DASH = 7'h3F
  - the 0–9 active-low font constants
  - the digit-index typedef (2-bit)
- Sub-module bcd_to_7seg: a combinational 4-bit digit in, active-low 7-bit pattern out. Codes 10–15 map to SEG_BLANK.
- Binary-to-decimal split is by comparison/subtraction on the small ranges (hours ≥10, minutes tens 0–5). No divider is used.

## Test plan
Bench parameters: REFRESH_DIV = 8, GHOST_CYC = 2, BLINK_DIV = 64.
- Reset then release with hours = 12, minutes = 0 → over one frame an cycles 1110, 1101, 1011, 0111, and seg shows 0, 0, 2, 1 in that order. an = 4'hF for 2 cycles at each slot start.
- hours = 9, minutes = 5 → d3 is blank (seg = 7'h7F while an = 0111), d2 = 9, d1 = 0, d0 = 5.
- Change minutes from 34 to 35 mid-frame (index 1) → the rest of that frame still shows 34, and 35 appears from the next index-0 slot.
- hours = 13 or minutes = 60 → all digits read 7'h3F and dp stays 1 for the whole frame.
- Colon: after reset, dp = 0 during index-2 slots for 64 cycles, then dp = 1 for 64 cycles, repeating. dp = 1 in every other slot.
- Assert reset for 1 cycle while an = 1011 → the next edge gives an = 4'hF, seg = 7'h7F, index = 0, and the sequence restarts per scenario 1.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the four-digit seven-segment clock display.
// All segment patterns are active-low with segment a on bit 0 and g on bit 6.
package seg_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [6:0] FONT_0 = 7'h40;
   localparam logic [6:0] FONT_1 = 7'h79;
   localparam logic [6:0] FONT_2 = 7'h24;
   localparam logic [6:0] FONT_3 = 7'h30;
   localparam logic [6:0] FONT_4 = 7'h19;
   localparam logic [6:0] FONT_5 = 7'h12;
   localparam logic [6:0] FONT_6 = 7'h02;
   localparam logic [6:0] FONT_7 = 7'h78;
   localparam logic [6:0] FONT_8 = 7'h00;
   localparam logic [6:0] FONT_9 = 7'h10;

   typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg_display_mux_bcd_to_7seg.sv
// Combinational decimal digit to active-low seven-segment pattern.
// Codes 10-15 produce a blank digit, which the top uses for leading-zero suppression.
module bcd_to_7seg
   import seg_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Font lookup
   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = FONT_0;
         4'd1:    seg = FONT_1;
         4'd2:    seg = FONT_2;
         4'd3:    seg = FONT_3;
         4'd4:    seg = FONT_4;
         4'd5:    seg = FONT_5;
         4'd6:    seg = FONT_6;
         4'd7:    seg = FONT_7;
         4'd8:    seg = FONT_8;
         4'd9:    seg = FONT_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed HH:MM driver: frame-coherent input latch, digit scan with
// anti-ghost blanking, leading-hour blanking, dash on invalid input and a blinking colon.
module seg_display_mux
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int GHOST_CYC   = 4,
   parameter int BLINK_DIV   = 50000000
)(
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic [3:0] hours,
   input  logic [5:0] minutes,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [RW-1:0] GHOST_END    = RW'(GHOST_CYC);
   localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{1'b1}};

   logic [RW-1:0] refresh_r;
   logic [BW-1:0] blink_r;
   digit_idx_t    index_r;
   logic          colon_on_r;
   logic [3:0]    hours_sh_r;
   logic [5:0]    minutes_sh_r;

   logic          valid_s;
   logic [3:0]    hours_tens_s, hours_ones_s, min_tens_s, min_ones_s;
   logic [3:0]    digit_s;
   logic [6:0]    font_s;
   logic [6:0]    next_seg_s;
   logic          next_dp_s;
   logic [3:0]    next_an_s;

   // Scan, blink and frame-latch state
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         refresh_r    <= '0;
         index_r      <= 2'd0;
         blink_r      <= '0;
         colon_on_r   <= 1'b1;
         hours_sh_r   <= 4'd12;
         minutes_sh_r <= 6'd0;
      end else begin
         if (refresh_r == REFRESH_LAST) begin
            refresh_r <= '0;
            index_r   <= index_r + 2'd1;
            // Only the last slot of a frame refreshes the shadows, so a frame never mixes values
            if (index_r == 2'd3) begin
               hours_sh_r   <= hours;
               minutes_sh_r <= minutes;
            end
         end else begin
            refresh_r <= refresh_r + RW'(1);
         end
         if (blink_r == BLINK_LAST) begin
            blink_r    <= '0;
            colon_on_r <= ~colon_on_r;
         end else begin
            blink_r <= blink_r + BW'(1);
         end
      end
   end

   // Decimal split by comparison on the small legal ranges
   always_comb begin
      valid_s = (hours_sh_r != 4'd0) && (hours_sh_r <= 4'd12) && (minutes_sh_r <= 6'd59);
      if (hours_sh_r >= 4'd10) begin
         hours_tens_s = 4'd1;
         hours_ones_s = hours_sh_r - 4'd10;
      end else begin
         hours_tens_s = 4'd15;
         hours_ones_s = hours_sh_r;
      end
      if (minutes_sh_r >= 6'd50) begin
         min_tens_s = 4'd5;
         min_ones_s = 4'(minutes_sh_r - 6'd50);
      end else if (minutes_sh_r >= 6'd40) begin
         min_tens_s = 4'd4;
         min_ones_s = 4'(minutes_sh_r - 6'd40);
      end else if (minutes_sh_r >= 6'd30) begin
         min_tens_s = 4'd3;
         min_ones_s = 4'(minutes_sh_r - 6'd30);
      end else if (minutes_sh_r >= 6'd20) begin
         min_tens_s = 4'd2;
         min_ones_s = 4'(minutes_sh_r - 6'd20);
      end else if (minutes_sh_r >= 6'd10) begin
         min_tens_s = 4'd1;
         min_ones_s = 4'(minutes_sh_r - 6'd10);
      end else begin
         min_tens_s = 4'd0;
         min_ones_s = 4'(minutes_sh_r);
      end
   end

   // Digit select for the active slot; blank hours tens is encoded as code 15
   always_comb begin
      digit_s   = 4'd15;
      next_an_s = AN_OFF;
      case (index_r)
         2'd0: begin digit_s = min_ones_s;   next_an_s = 4'b1110; end
         2'd1: begin digit_s = min_tens_s;   next_an_s = 4'b1101; end
         2'd2: begin digit_s = hours_ones_s; next_an_s = 4'b1011; end
         2'd3: begin digit_s = hours_tens_s; next_an_s = 4'b0111; end
         default: begin digit_s = 4'd15;     next_an_s = AN_OFF;  end
      endcase
      if (refresh_r < GHOST_END) begin
         next_an_s = AN_OFF;
      end else begin
         next_an_s = next_an_s;
      end
      if (valid_s) begin
         next_seg_s = font_s;
      end else begin
         next_seg_s = SEG_DASH;
      end
      next_dp_s = ~(valid_s && colon_on_r && (index_r == 2'd2));
   end

   bcd_to_7seg u_font (
      .digit (digit_s),
      .seg   (font_s)
   );

   // Registered display outputs
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         seg <= SEG_BLANK;
         dp  <= 1'b1;
         an  <= AN_OFF;
      end else begin
         seg <= next_seg_s;
         dp  <= next_dp_s;
         an  <= next_an_s;
      end
   end

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench: a behavioural cycle model predicts each edge's outputs,
// queues them as stimulus is applied, and compares them after the edge.
module tb_seg_display_mux;

   localparam int R = 8;
   localparam int G = 2;
   localparam int B = 64;

   logic       clk_100MHz = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] hours = 4'd12;
   logic [5:0] minutes = 6'd0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] an;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;

   int m_cnt = 0, m_idx = 0, m_bcnt = 0, m_h = 12, m_m = 0;
   bit m_colon = 1'b1;

   seg_display_mux #(.REFRESH_DIV(R), .GHOST_CYC(G), .BLINK_DIV(B)) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .hours      (hours),
      .minutes    (minutes),
      .seg        (seg),
      .dp         (dp),
      .an         (an)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   function automatic logic [6:0] font(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // Predict, advance the model, clock once, then compare
   task automatic step();
      exp_t e;
      exp_t got;
      logic [3:0] onehot;
      bit valid;
      if (reset) begin
         e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF;
      end else begin
         valid = (m_h >= 1) && (m_h <= 12) && (m_m <= 59);
         case (m_idx)
            0: e.seg = font(m_m % 10);
            1: e.seg = font(m_m / 10);
            2: e.seg = font(m_h % 10);
            default: e.seg = (m_h < 10) ? 7'h7F : font(m_h / 10);
         endcase
         if (!valid) e.seg = 7'h3F;
         e.dp = !(valid && m_colon && m_idx == 2);
         onehot = 4'b0001 << m_idx;
         e.an = (m_cnt < G) ? 4'hF : ~onehot;
      end
      q.push_back(e);
      if (reset) begin
         m_cnt = 0; m_idx = 0; m_bcnt = 0; m_colon = 1'b1; m_h = 12; m_m = 0;
      end else begin
         if (m_cnt == R - 1) begin
            m_cnt = 0;
            if (m_idx == 3) begin m_h = int'(hours); m_m = int'(minutes); end
            m_idx = (m_idx + 1) % 4;
         end else begin
            m_cnt = m_cnt + 1;
         end
         if (m_bcnt == B - 1) begin m_bcnt = 0; m_colon = !m_colon; end
         else m_bcnt = m_bcnt + 1;
      end
      @(posedge clk_100MHz);
      #1;
      got = q.pop_front();
      total++;
      assert (seg === got.seg) else begin
         bad++; $error("FAIL seg t=%0t observed=%h expected=%h", $time, seg, got.seg);
      end
      total++;
      assert (dp === got.dp) else begin
         bad++; $error("FAIL dp t=%0t observed=%b expected=%b", $time, dp, got.dp);
      end
      total++;
      assert (an === got.an) else begin
         bad++; $error("FAIL an t=%0t observed=%b expected=%b", $time, an, got.an);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Advance until the model reaches a given slot position, bounded
   task automatic wait_pos(input int idx, input int cnt);
      int k = 0;
      while (!(m_idx == idx && m_cnt == cnt) && k < 4 * R + 2) begin
         step();
         k++;
      end
      total++;
      assert (m_idx == idx && m_cnt == cnt) else begin
         bad++; $error("FAIL wait_pos observed=%0d/%0d expected=%0d/%0d", m_idx, m_cnt, idx, cnt);
      end
   endtask

   initial begin
      #1;
      // Reset, then a full 12:00 frame
      run(3);
      reset = 1'b0;
      run(5 * R);
      // Leading blank
      hours = 4'd9; minutes = 6'd5;
      run(10 * R);
      // Mid-frame change stays invisible until the next frame
      hours = 4'd10; minutes = 6'd34;
      run(5 * R);
      wait_pos(1, 3);
      minutes = 6'd35;
      run(8 * R);
      // Invalid inputs
      hours = 4'd13; minutes = 6'd0;
      run(9 * R);
      hours = 4'd5; minutes = 6'd60;
      run(9 * R);
      hours = 4'd0; minutes = 6'd59;
      run(9 * R);
      // Colon across several blink periods
      hours = 4'd11; minutes = 6'd59;
      run(5 * B);
      // Single-cycle reset while the hours-ones digit is lit
      wait_pos(2, 5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      hours = 4'd12; minutes = 6'd0;
      run(6 * R);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
